// File: rtl/burst_tick_gen.sv
// burst_tick_gen: emits a burst of COUNT indexed ticks, each preceded by DIV
// wait cycles, handed downstream over a valid/ready handshake, followed by a
// one-cycle done pulse.
// Optional build macro: TICK_LOG_EN adds a simulation-only trace of accepted
// ticks ("tick N") and burst completion ("burst done").
module burst_tick_gen #(
    parameter int DIV   = 4,
    parameter int COUNT = 32,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             tick_ready,
    output logic             tick_valid,
    output logic [IDX_W-1:0] tick_idx,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_EMIT,
        S_DONE
    } state_t;

    localparam int               CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]    DIV_LOAD = CW'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(COUNT - 1);

    state_t           state, state_nx;
    logic [CW-1:0]    div_cnt, div_nx;
    logic [IDX_W-1:0] idx_nx;
    logic             hs;

    // tick_valid is only ever high in EMIT, so this is the accept condition.
    assign hs = tick_valid & tick_ready;

    // Next-state, divider and index update; stop pre-empts everything but IDLE.
    always_comb begin
        state_nx = state;
        div_nx   = div_cnt;
        idx_nx   = tick_idx;
        case (state)
            S_IDLE: begin
                if (start && !stop) begin
                    state_nx = S_WAIT;
                    div_nx   = DIV_LOAD;
                    idx_nx   = '0;
                end
            end
            S_WAIT: begin
                if (stop)
                    state_nx = S_IDLE;
                else if (div_cnt != '0)
                    div_nx = div_cnt - CW'(1);
                else
                    state_nx = S_EMIT;
            end
            S_EMIT: begin
                if (stop) begin
                    state_nx = S_IDLE;
                end else if (hs) begin
                    if (tick_idx == IDX_LAST) begin
                        state_nx = S_DONE;
                    end else begin
                        state_nx = S_WAIT;
                        idx_nx   = tick_idx + IDX_W'(1);
                        div_nx   = DIV_LOAD;
                    end
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // State register; outputs are decoded from the next state so they are flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            div_cnt    <= '0;
            tick_idx   <= '0;
            tick_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            div_cnt    <= div_nx;
            tick_idx   <= idx_nx;
            tick_valid <= (state_nx == S_EMIT);
            busy       <= (state_nx == S_WAIT) || (state_nx == S_EMIT);
            done       <= (state_nx == S_DONE);
        end
    end

`ifdef TICK_LOG_EN
    // Simulation-only trace of accepted ticks and of the done pulse.
    always @(posedge clk) begin
        if (!reset && !stop && tick_valid && tick_ready)
            $display("tick %0d", tick_idx);
        if (!reset && done)
            $display("burst done");
    end
`else
`endif

endmodule

// File: tb/tb_burst_tick_gen.sv
// Scoreboard bench for burst_tick_gen: stimulus pushes the expected tick
// sequence per burst, a negedge monitor pops on every handshake / done pulse
// and also checks tick spacing, stall stability and done latency.
module tb_burst_tick_gen;

    localparam int DIV   = 4;
    localparam int COUNT = 32;
    localparam int IDX_W = 5;
    localparam int DONE_MARK = -1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             tick_ready = 1'b1;
    logic             tick_valid;
    logic [IDX_W-1:0] tick_idx;
    logic             busy;
    logic             done;

    logic             start1 = 1'b0;
    logic             stop1 = 1'b0;
    logic             ready1 = 1'b1;
    logic             valid1;
    logic [0:0]       idx1;
    logic             busy1;
    logic             done1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rmode = 0;
    int exp_q[$];

    burst_tick_gen #(.DIV(DIV), .COUNT(COUNT), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .tick_ready(tick_ready), .tick_valid(tick_valid), .tick_idx(tick_idx),
        .busy(busy), .done(done)
    );

    burst_tick_gen #(.DIV(1), .COUNT(1), .IDX_W(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .stop(stop1),
        .tick_ready(ready1), .tick_valid(valid1), .tick_idx(idx1),
        .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ready pattern: 0 = always ready, 1 = random, 2 = held low
    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       tick_ready = 1'b1;
            1:       tick_ready = 1'($urandom_range(0, 1));
            default: tick_ready = 1'b0;
        endcase
    end

    // Monitor / scoreboard
    logic p_valid = 1'b0, p_ready = 1'b0, p_stop = 1'b0, p_reset = 1'b1;
    logic p_busy = 1'b0, p_done = 1'b0;
    logic [IDX_W-1:0] p_idx = '0;
    int ref_edge = 0;
    bit ref_ok = 0;
    int last_hs = 0;
    int mon_e;

    always @(negedge clk) begin
        if (busy === 1'b1 && !p_busy) begin
            ref_edge = cyc;
            ref_ok = 1;
        end
        if (tick_valid === 1'b1 && !p_valid) begin
            chk("tick_spacing", cyc, ref_ok ? ref_edge + DIV : 32'hffff_ffff);
            ref_ok = 0;
        end
        if (p_valid && !p_ready && !p_stop && !p_reset) begin
            chk("stall_valid", {31'd0, tick_valid}, 1);
            chk("stall_idx", {27'd0, tick_idx}, {27'd0, p_idx});
        end
        if (tick_valid === 1'b1 && tick_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("tick_unexpected", {27'd0, tick_idx}, 32'hffff_fffe);
            end else begin
                mon_e = exp_q.pop_front();
                chk("tick_idx", {27'd0, tick_idx}, mon_e);
            end
            ref_edge = cyc + 1;
            ref_ok = 1;
            last_hs = cyc;
        end
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("done_unexpected", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("done_order", mon_e, DONE_MARK);
            end
            chk("done_latency", cyc, last_hs + 1);
            chk("done_single", {31'd0, p_done}, 0);
        end
        p_valid = (tick_valid === 1'b1);
        p_ready = (tick_ready === 1'b1);
        p_stop  = stop;
        p_reset = reset;
        p_busy  = (busy === 1'b1);
        p_done  = (done === 1'b1);
        p_idx   = tick_idx;
    end

    task automatic push_burst(input int n, input bit with_done);
        for (int i = 0; i < n; i++) exp_q.push_back(i);
        if (with_done) exp_q.push_back(DONE_MARK);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_hs(input int k, input string nm);
        int n = 0;
        bit hit = 0;
        while (!hit && n < 3000) begin
            @(negedge clk);
            n++;
            if (tick_valid === 1'b1 && tick_ready === 1'b1 && tick_idx == IDX_W'(k)) hit = 1;
        end
        chk(nm, {31'd0, hit}, 1);
    endtask

    task automatic wait_vis(input int k, input string nm);
        int n = 0;
        bit hit = 0;
        while (!hit && n < 3000) begin
            @(negedge clk);
            n++;
            if (tick_valid === 1'b1 && tick_idx == IDX_W'(k)) hit = 1;
        end
        chk(nm, {31'd0, hit}, 1);
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        bit hit = 0;
        while (!hit && n < 5000) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) hit = 1;
        end
        chk(nm, {31'd0, hit}, 1);
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_valid"}, {31'd0, tick_valid}, 0);
        chk({nm, "_busy"}, {31'd0, busy}, 0);
        chk({nm, "_done"}, {31'd0, done}, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_idle("reset");
        chk("reset_idx", {27'd0, tick_idx}, 0);

        // full burst, always ready
        rmode = 0;
        push_burst(COUNT, 1);
        pulse_start();
        wait_done("b1_done_seen");
        @(negedge clk);
        chk_idle("b1_after");

        // backpressure on idx 5, then random ready
        push_burst(COUNT, 1);
        pulse_start();
        wait_hs(4, "bp_hs4");
        rmode = 2;
        wait_vis(5, "bp_vis5");
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", {31'd0, tick_valid}, 1);
            chk("bp_idx", {27'd0, tick_idx}, 5);
            if (i < 2) @(negedge clk);
        end
        rmode = 1;
        wait_done("bp_done_seen");
        @(negedge clk);
        chk_idle("bp_after");

        // abort while idx 10 is waiting
        rmode = 0;
        push_burst(10, 0);
        pulse_start();
        wait_hs(9, "ab_hs9");
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        @(negedge clk);
        chk_idle("abort");
        repeat (10) @(negedge clk);
        chk_idle("abort_quiet");

        // restart with start held through the whole burst
        push_burst(COUNT, 1);
        @(posedge clk); #1 start = 1'b1;
        wait_done("hold_done_seen");
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("hold_one_burst", {31'd0, busy}, 0);
        end

        // start together with stop in IDLE
        @(posedge clk); #1 begin start = 1'b1; stop = 1'b1; end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_idle("startstop");
        end
        @(posedge clk); #1 begin start = 1'b0; stop = 1'b0; end

        // reset while idx 20 is waiting
        push_burst(20, 0);
        pulse_start();
        wait_hs(19, "rs_hs19");
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk_idle("midreset");
        chk("midreset_idx", {27'd0, tick_idx}, 0);
        repeat (5) @(negedge clk);

        // random-ready bursts
        rmode = 1;
        for (int b = 0; b < 2; b++) begin
            push_burst(COUNT, 1);
            pulse_start();
            wait_done("rand_done_seen");
        end
        rmode = 0;
        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);

        // single-tick instance, DIV=1 COUNT=1
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        @(negedge clk);
        chk("one_c1_valid", {31'd0, valid1}, 0);
        chk("one_c1_busy", {31'd0, busy1}, 1);
        @(negedge clk);
        chk("one_c2_valid", {31'd0, valid1}, 1);
        chk("one_c2_idx", {31'd0, idx1}, 0);
        @(negedge clk);
        chk("one_c3_done", {31'd0, done1}, 1);
        chk("one_c3_valid", {31'd0, valid1}, 0);
        @(negedge clk);
        chk("one_c4_done", {31'd0, done1}, 0);
        chk("one_c4_busy", {31'd0, busy1}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
